board_rx_buffer: RTL and testbench
==================================

BOARD_RX_BUFFER -- requirements
Module: board_rx_buffer

Interface
REQ-001 Parameter DEPTH, default 2, meaning FIFO entries; SHALL be a power of two and at least 2.
REQ-002 Parameter CNT_W, default 8, meaning width of each saturating error counter.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk_in  input  1  system clock; all state SHALL change on its rising edge.
REQ-005 rst_in  input  1  asynchronous, active-low reset.
REQ-006 data_in  input  162  board word from the serial receiver: 81 cells, 2 bits each, cell k at bits [2k+1:2k].
REQ-007 ready_in  input  1  one-cycle strobe; data_in is valid in that cycle only.
REQ-008 board_out  output  162  head-of-FIFO board.
REQ-009 black_cnt_out  output  7  count of BLACK cells in board_out.
REQ-010 white_cnt_out  output  7  count of WHITE cells in board_out.
REQ-011 valid_out  output  1  FIFO non-empty; board_out and both counts are valid.
REQ-012 ack_in  input  1  consumer pops the head when ack_in and valid_out are both high.
REQ-013 illegal_cnt_out  output  CNT_W  frames rejected for an illegal cell; saturating.
REQ-014 ovf_cnt_out  output  CNT_W  frames dropped because the FIFO was full; saturating.

Function
REQ-015 Cell codes SHALL be: 00 EMPTY, 01 BLACK, 10 WHITE, 11 ILLEGAL.
REQ-016 Stage 1: on ready_in, data_in SHALL be registered and a one-cycle internal strobe s1 raised in the next cycle.
REQ-017 Stage 2: in the s1 cycle, the block SHALL check all 81 cells and compute the BLACK and WHITE counts combinationally.
REQ-018 Any ILLEGAL cell SHALL discard the frame and increment illegal_cnt_out; the FIFO SHALL not change.
REQ-019 A legal frame SHALL be written to the FIFO as {board, black count, white count} at the end of the s1 cycle.
REQ-020 Latency: ready_in in cycle N into an empty FIFO SHALL give valid_out high in cycle N+2.
REQ-021 When the FIFO is full in the s1 cycle and no pop occurs, the frame SHALL be dropped and ovf_cnt_out incremented.
REQ-022 When the FIFO is full and a pop occurs in the same s1 cycle, the write SHALL be accepted and the occupancy stay at DEPTH.
REQ-023 A simultaneous push and pop on a non-empty FIFO SHALL leave the occupancy unchanged.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH, with one extra bit used to tell full from empty.
REQ-025 board_out and the counts SHALL change only on a pop or on a write into an empty FIFO.
REQ-026 While valid_out is high and ack_in is low, board_out and the counts SHALL hold stable.
REQ-027 A ready_in strobe in every cycle SHALL be accepted at full throughput, with no frame lost except under REQ-021.
REQ-028 Counters SHALL saturate at 2^CNT_W-1 and not wrap.

Reset
REQ-029 Asserting rst_in SHALL immediately clear the FIFO and both pipeline registers; any frame in flight SHALL be lost.
REQ-030 Reset values SHALL be: valid_out=0, board_out=0, black_cnt_out=0, white_cnt_out=0, illegal_cnt_out=0, ovf_cnt_out=0.
REQ-031 After rst_in deasserts, the first ready_in SHALL be processed normally.

Configuration
REQ-032 The macro BOARD_RX_DEDUP_EN SHALL control duplicate-frame suppression.
REQ-033 With BOARD_RX_DEDUP_EN defined, the block SHALL keep the last board written to the FIFO.
REQ-034 With BOARD_RX_DEDUP_EN defined, a legal frame equal to that board SHALL be discarded silently, with no counter change.
REQ-035 The stored board SHALL be cleared to all-EMPTY on reset.
REQ-036 Without BOARD_RX_DEDUP_EN, every legal frame SHALL be written and no comparison register SHALL exist.

Structure
REQ-037 Package board_pkg SHALL hold: BOARD_BITS=162, N_CELLS=81, the cell-code enum, and the FIFO entry struct {board, black, white}.
REQ-038 The FIFO storage and pointers SHALL be a sub-module named board_fifo, parameterised by DEPTH and the entry type.

Verification
REQ-039 Reset, then 162'h2_AAAA_..._AAAA with ready_in at N -> valid_out at N+2; white_cnt_out=81, black_cnt_out=0.
REQ-040 Cell 40 set to 11 -> valid_out stays 0; illegal_cnt_out=1.
REQ-041 DEPTH=2, ack_in=0, 3 legal frames -> first two held in order; ovf_cnt_out=1.
REQ-042 FIFO full, ack_in=1 in the third frame's s1 cycle -> frame accepted; ovf_cnt_out=0.
REQ-043 BOARD_RX_DEDUP_EN defined, same frame sent twice -> one FIFO entry; without the macro -> two entries.
REQ-044 rst_in asserted one cycle after ready_in -> valid_out=0 and never rises for that frame.

Source files
------------

// File: rtl/board_pkg.sv
// Board receive buffer shared types.
// Holds the board geometry constants, the 2-bit cell encoding, the FIFO
// entry layout and a cell-counting helper used by the receive pipeline.
package board_pkg;

    localparam int unsigned BOARD_BITS = 162;
    localparam int unsigned N_CELLS    = 81;
    // 81 fits in 7 bits
    localparam int unsigned CNT_BITS   = 7;

    typedef enum logic [1:0] {
        CELL_EMPTY   = 2'b00,
        CELL_BLACK   = 2'b01,
        CELL_WHITE   = 2'b10,
        CELL_ILLEGAL = 2'b11
    } cell_e;

    typedef struct packed {
        logic [BOARD_BITS-1:0] board;
        logic [CNT_BITS-1:0]   black;
        logic [CNT_BITS-1:0]   white;
    } board_entry_t;

    // Number of cells in b holding the given code.
    function automatic logic [CNT_BITS-1:0] count_cells(
        input logic [BOARD_BITS-1:0] b,
        input cell_e                 code
    );
        logic [CNT_BITS-1:0] n;
        n = '0;
        for (int unsigned k = 0; k < N_CELLS; k++) begin
            if (b[2*k +: 2] == code) begin
                n = n + CNT_BITS'(1);
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/board_rx_buffer_if.sv
// Board receive buffer bus.
// master: serial receiver + consumer side (drives data_in, ready_in, ack_in).
// slave : board_rx_buffer side (drives board_out, counts, valid_out).
interface board_rx_buffer_if;
    import board_pkg::*;

    logic [BOARD_BITS-1:0] data_in;
    logic                  ready_in;
    logic [BOARD_BITS-1:0] board_out;
    logic [CNT_BITS-1:0]   black_cnt_out;
    logic [CNT_BITS-1:0]   white_cnt_out;
    logic                  valid_out;
    logic                  ack_in;

    modport master (
        output data_in, ready_in, ack_in,
        input  board_out, black_cnt_out, white_cnt_out, valid_out
    );

    modport slave (
        input  data_in, ready_in, ack_in,
        output board_out, black_cnt_out, white_cnt_out, valid_out
    );

endinterface

// File: rtl/board_fifo.sv
// Board FIFO: DEPTH-entry storage with wrap-around pointers (one extra bit
// separates full from empty) and a registered head entry.
// Ports:
//   clk_in, rst_in  clock, async active-low reset
//   push, wdata     write request / entry (refused when full without a pop)
//   pop             remove head (ignored when empty)
//   full_c          combinational full flag
//   valid           registered non-empty flag
//   head            registered head entry; changes only on pop or on a
//                   write into an empty FIFO
// DEPTH must be a power of two, at least 2.
module board_fifo #(
    parameter int unsigned DEPTH   = 2,
    parameter type         entry_t = board_pkg::board_entry_t
) (
    input  logic   clk_in,
    input  logic   rst_in,
    input  logic   push,
    input  entry_t wdata,
    input  logic   pop,
    output logic   full_c,
    output logic   valid,
    output entry_t head
);

    localparam int unsigned PW = $clog2(DEPTH);

    entry_t        mem [DEPTH];
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;
    logic [PW:0]   wr_ptr_nxt;
    logic [PW:0]   rd_ptr_nxt;
    logic          do_push;
    logic          do_pop;
    entry_t        head_nxt;

    assign full_c = (wr_ptr[PW] != rd_ptr[PW]) &&
                    (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

    // Pointer advance and next head selection.
    always_comb begin
        do_pop     = pop && valid;
        do_push    = push && (!full_c || do_pop);
        wr_ptr_nxt = wr_ptr + (PW+1)'(do_push);
        rd_ptr_nxt = rd_ptr + (PW+1)'(do_pop);
        head_nxt   = head;
        if (do_pop) begin
            // Next head is either already stored or is the entry arriving now.
            if (rd_ptr_nxt != wr_ptr) begin
                head_nxt = mem[rd_ptr_nxt[PW-1:0]];
            end else if (do_push) begin
                head_nxt = wdata;
            end
        end else if (do_push && !valid) begin
            head_nxt = wdata;
        end
    end

    // Pointers, valid flag and head register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            valid  <= 1'b0;
            head   <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            valid  <= (wr_ptr_nxt != rd_ptr_nxt);
            head   <= head_nxt;
        end
    end

    // Entry storage; contents are meaningless while the pointers say empty.
    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem[wr_ptr[PW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/board_rx_buffer.sv
// Board receive buffer: registers boards from the serial receiver, rejects
// frames containing an ILLEGAL cell, counts BLACK/WHITE cells and queues
// legal frames in a DEPTH-entry FIFO for the consumer.
// Ports:
//   clk_in, rst_in   clock, async active-low reset
//   bus (slave)      data_in/ready_in in; board_out, black/white counts,
//                    valid_out out; ack_in pops the head
//   illegal_cnt_out  saturating count of frames with an ILLEGAL cell
//   ovf_cnt_out      saturating count of frames dropped on a full FIFO
// Optional: define BOARD_RX_DEDUP_EN to discard a legal frame identical to
// the last board written to the FIFO.
module board_rx_buffer
    import board_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic                clk_in,
    input  logic                rst_in,
    board_rx_buffer_if.slave    bus,
    output logic [CNT_W-1:0]    illegal_cnt_out,
    output logic [CNT_W-1:0]    ovf_cnt_out
);

    logic                  s1;
    logic [BOARD_BITS-1:0] s1_data;
    logic                  illegal_c;
    logic                  legal_c;
    logic                  dup_c;
    logic                  pop_c;
    logic                  push_c;
    logic                  ovf_c;
    logic                  full_c;
    board_entry_t          entry_c;
    board_entry_t          head;

    // Stage 1: capture the strobed board.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            s1      <= 1'b0;
            s1_data <= '0;
        end else begin
            s1 <= bus.ready_in;
            if (bus.ready_in) begin
                s1_data <= bus.data_in;
            end
        end
    end

    // Stage 2: classify the captured board and decide push/drop.
    always_comb begin
        entry_c.board = s1_data;
        entry_c.black = count_cells(s1_data, CELL_BLACK);
        entry_c.white = count_cells(s1_data, CELL_WHITE);
        illegal_c     = s1 && (count_cells(s1_data, CELL_ILLEGAL) != '0);
        legal_c       = s1 && !illegal_c;
        pop_c         = bus.ack_in && bus.valid_out;
        // A pop in the same cycle frees the slot for a full FIFO.
        push_c        = legal_c && !dup_c && (!full_c || pop_c);
        ovf_c         = legal_c && !dup_c && full_c && !pop_c;
    end

`ifdef BOARD_RX_DEDUP_EN
    logic [BOARD_BITS-1:0] last_board;

    // Last board accepted into the FIFO; all-EMPTY after reset.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            last_board <= '0;
        end else if (push_c) begin
            last_board <= s1_data;
        end
    end

    assign dup_c = (s1_data == last_board);
`else
    assign dup_c = 1'b0;
`endif

    // Saturating error counters.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            illegal_cnt_out <= '0;
            ovf_cnt_out     <= '0;
        end else begin
            if (illegal_c && (illegal_cnt_out != '1)) begin
                illegal_cnt_out <= illegal_cnt_out + CNT_W'(1);
            end
            if (ovf_c && (ovf_cnt_out != '1)) begin
                ovf_cnt_out <= ovf_cnt_out + CNT_W'(1);
            end
        end
    end

    board_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (board_entry_t)
    ) u_fifo (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .push   (push_c),
        .wdata  (entry_c),
        .pop    (pop_c),
        .full_c (full_c),
        .valid  (bus.valid_out),
        .head   (head)
    );

    assign bus.board_out     = head.board;
    assign bus.black_cnt_out = head.black;
    assign bus.white_cnt_out = head.white;

endmodule

// File: tb/tb_board_rx_buffer.sv
// Scoreboard bench for board_rx_buffer (DEPTH=2, CNT_W=8). Stimulus pushes
// expected FIFO entries; the negedge monitor pops and compares on every
// accepted pop and checks head stability while the consumer stalls.
module tb_board_rx_buffer;
    import board_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned BW    = BOARD_BITS;

    logic             clk_in = 1'b0;
    logic             rst_in = 1'b0;
    logic [CNT_W-1:0] illegal_cnt_out;
    logic [CNT_W-1:0] ovf_cnt_out;

    board_rx_buffer_if bus();

    board_rx_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .bus             (bus),
        .illegal_cnt_out (illegal_cnt_out),
        .ovf_cnt_out     (ovf_cnt_out)
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;
    int pops  = 0;
    board_entry_t sb[$];
    board_entry_t exp_e;
    logic         prev_hold = 1'b0;
    logic [BW-1:0] prev_board;
    logic [BW-1:0] bd_a, bd_b, bd_c, bd_e, bd_f;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic board_entry_t ent(input logic [BW-1:0] b, input int blk, input int wht);
        board_entry_t e;
        e.board = b;
        e.black = CNT_BITS'(blk);
        e.white = CNT_BITS'(wht);
        return e;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic send(input logic [BW-1:0] b);
        bus.ready_in = 1'b1;
        bus.data_in  = b;
        step(1);
        bus.ready_in = 1'b0;
    endtask

    task automatic do_reset();
        bus.ready_in = 1'b0;
        bus.ack_in   = 1'b0;
        rst_in       = 1'b0;
        step(2);
        sb.delete();
        rst_in = 1'b1;
        step(1);
    endtask

    task automatic drain(input string name);
        int cyc;
        cyc = 0;
        bus.ack_in = 1'b1;
        while ((sb.size() != 0 || bus.valid_out) && cyc < 100) begin
            step(1);
            cyc++;
        end
        bus.ack_in = 1'b0;
        total++;
        if (cyc >= 100) begin
            bad++;
            $display("FAIL %s: drain timed out, %0d entries left", name, sb.size());
        end
    endtask

    // Monitor: compare every popped head against the scoreboard.
    always @(negedge clk_in) begin
        if (rst_in) begin
            if (prev_hold) chk("hold_board", bus.board_out, prev_board);
            if (bus.valid_out && bus.ack_in) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_unexpected: got %0h expected none", bus.board_out);
                end else begin
                    exp_e = sb.pop_front();
                    chk("pop_board", bus.board_out, exp_e.board);
                    chk("pop_black", BW'(bus.black_cnt_out), BW'(exp_e.black));
                    chk("pop_white", BW'(bus.white_cnt_out), BW'(exp_e.white));
                    pops++;
                end
            end
            prev_hold  = bus.valid_out && !bus.ack_in;
            prev_board = bus.board_out;
        end else begin
            prev_hold = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int p0;
        int exp_n;
        logic seen_valid;

        bus.data_in  = '0;
        bus.ready_in = 1'b0;
        bus.ack_in   = 1'b0;
        for (int k = 0; k < 81; k++) begin
            bd_a[2*k +: 2] = 2'b10;
            bd_b[2*k +: 2] = 2'b01;
            bd_c[2*k +: 2] = (k % 3 == 0) ? 2'b00 : ((k % 3 == 1) ? 2'b01 : 2'b10);
        end
        bd_e          = bd_a;
        bd_e[81:80]   = 2'b11;
        bd_f          = '0;
        bd_f[1:0]     = 2'b01;

        // Reset values
        step(2);
        chk("rst_valid", BW'(bus.valid_out), BW'(1'b0));
        chk("rst_board", bus.board_out, '0);
        chk("rst_black", BW'(bus.black_cnt_out), '0);
        chk("rst_white", BW'(bus.white_cnt_out), '0);
        chk("rst_illegal", BW'(illegal_cnt_out), '0);
        chk("rst_ovf", BW'(ovf_cnt_out), '0);
        rst_in = 1'b1;
        step(1);

        // Latency: strobe in N, valid in N+2
        sb.push_back(ent(bd_a, 0, 81));
        bus.ready_in = 1'b1;
        bus.data_in  = bd_a;
        step(1);
        bus.ready_in = 1'b0;
        chk("lat_n1_valid", BW'(bus.valid_out), BW'(1'b0));
        step(1);
        chk("lat_n2_valid", BW'(bus.valid_out), BW'(1'b1));
        chk("lat_white", BW'(bus.white_cnt_out), BW'(7'd81));
        chk("lat_black", BW'(bus.black_cnt_out), BW'(7'd0));
        step(3);
        drain("t1");

        // Illegal cell 40
        send(bd_e);
        step(4);
        chk("ill_valid", BW'(bus.valid_out), BW'(1'b0));
        chk("ill_cnt", BW'(illegal_cnt_out), BW'(8'd1));
        chk("ill_ovf", BW'(ovf_cnt_out), BW'(8'd0));

        // Overflow: three back-to-back frames, no ack
        do_reset();
        sb.push_back(ent(bd_b, 81, 0));
        sb.push_back(ent(bd_c, 27, 27));
        send(bd_b);
        send(bd_c);
        send(bd_f);
        step(4);
        chk("ovf_cnt", BW'(ovf_cnt_out), BW'(8'd1));
        chk("ovf_valid", BW'(bus.valid_out), BW'(1'b1));
        chk("ovf_head", bus.board_out, bd_b);
        step(5);
        chk("ovf_head_held", bus.board_out, bd_b);
        drain("t3");

        // Full FIFO, pop in the third frame's s1 cycle
        do_reset();
        sb.push_back(ent(bd_a, 0, 81));
        sb.push_back(ent(bd_b, 81, 0));
        sb.push_back(ent(bd_f, 1, 0));
        send(bd_a);
        send(bd_b);
        step(3);
        send(bd_f);
        bus.ack_in = 1'b1;
        step(1);
        bus.ack_in = 1'b0;
        step(2);
        chk("fullpop_ovf", BW'(ovf_cnt_out), BW'(8'd0));
        chk("fullpop_head", bus.board_out, bd_b);
        drain("t4");

        // Duplicate frame
        do_reset();
        p0 = pops;
`ifdef BOARD_RX_DEDUP_EN
        exp_n = 1;
        sb.push_back(ent(bd_c, 27, 27));
`else
        exp_n = 2;
        sb.push_back(ent(bd_c, 27, 27));
        sb.push_back(ent(bd_c, 27, 27));
`endif
        send(bd_c);
        step(2);
        send(bd_c);
        step(3);
        drain("t5");
        chk("dup_entries", BW'(pops - p0), BW'(exp_n));

        // Full throughput with the consumer always ready
        do_reset();
        p0 = pops;
        bus.ack_in = 1'b1;
        sb.push_back(ent(bd_a, 0, 81));
        sb.push_back(ent(bd_b, 81, 0));
        sb.push_back(ent(bd_c, 27, 27));
        sb.push_back(ent(bd_f, 1, 0));
        send(bd_a);
        send(bd_b);
        send(bd_c);
        send(bd_f);
        step(2);
        drain("t6");
        chk("tput_entries", BW'(pops - p0), BW'(4));
        chk("tput_ovf", BW'(ovf_cnt_out), BW'(8'd0));

        // Reset one cycle after the strobe loses the frame
        do_reset();
        send(bd_c);
        rst_in = 1'b0;
        step(1);
        rst_in = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            seen_valid = seen_valid | bus.valid_out;
        end
        chk("rstfly_valid", BW'(seen_valid), BW'(1'b0));
        sb.push_back(ent(bd_a, 0, 81));
        send(bd_a);
        step(1);
        chk("rstfly_next_valid", BW'(bus.valid_out), BW'(1'b1));
        drain("t7");

        // Illegal counter saturation
        do_reset();
        bus.ready_in = 1'b1;
        bus.data_in  = bd_e;
        step(260);
        bus.ready_in = 1'b0;
        step(3);
        chk("sat_illegal", BW'(illegal_cnt_out), BW'(8'd255));
        chk("sat_valid", BW'(bus.valid_out), BW'(1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
